// File: rtl/mul_seq.sv
// mul_seq: iterative unsigned shift-add multiplier, one partial product per cycle.
// Ports:
//   clk_in, rst_in (async, active-high)   clock / reset
//   start_in                              request a multiply; sampled in IDLE only
//   a_in, b_in [WIDTH-1:0]                multiplicand / multiplier
//   seg_sel_in                            0 = low product half, 1 = high half on seg_out
//   busy_out                              high while RUN or DONE
//   done_out                              one-cycle pulse when prod_out is updated
//   prod_out [2*WIDTH-1:0]                product of the last completed multiply
//   seg_out [WIDTH-1:0]                   selected half of prod_out (combinational)
module mul_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               start_in,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  input  logic               seg_sel_in,
  output logic               busy_out,
  output logic               done_out,
  output logic [2*WIDTH-1:0] prod_out,
  output logic [WIDTH-1:0]   seg_out
);

  localparam int unsigned PW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [CW-1:0]      count, count_n;
  logic [PW-1:0]      p, p_n;
  logic [WIDTH-1:0]   mcand, mcand_n;
  logic [2*WIDTH-1:0] prod_n;
  logic               busy_n, done_n;
  logic [WIDTH:0]     upper;
  logic [PW-1:0]      shifted;

  // State and datapath registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      count    <= '0;
      p        <= '0;
      mcand    <= '0;
      prod_out <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      p        <= p_n;
      mcand    <= mcand_n;
      prod_out <= prod_n;
      busy_out <= busy_n;
      done_out <= done_n;
    end
  end

  // Next-state, iteration step and registered-output decode
  always_comb begin
    state_n = state;
    count_n = count;
    p_n     = p;
    mcand_n = mcand;
    prod_n  = prod_out;
    busy_n  = busy_out;
    done_n  = 1'b0;
    upper   = p[PW-1:WIDTH];
    shifted = '0;

    case (state)
      IDLE: begin
        if (start_in) begin
          mcand_n = a_in;
          p_n     = {1'b0, WIDTH'(0), b_in};
          count_n = '0;
          state_n = RUN;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        // Carry bit of upper holds the overflow of H + MCAND before the shift
        if (p[0]) begin
          upper = (WIDTH + 1)'(p[2*WIDTH-1:WIDTH]) + (WIDTH + 1)'(mcand);
        end
        shifted = {1'b0, upper, p[WIDTH-1:1]};
        p_n     = shifted;
        count_n = count + CW'(1);
        if (count == CW'(WIDTH - 1)) begin
          prod_n  = shifted[2*WIDTH-1:0];
          state_n = DONE;
          done_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign seg_out = seg_sel_in ? prod_out[2*WIDTH-1:WIDTH] : prod_out[WIDTH-1:0];

endmodule
